// File: rtl/inv_mix_columns_seq.sv
// -----------------------------------------------------------------------------
// inv_mix_columns_seq
//
// Sequences one 128-bit AES state through a shared, external, purely
// combinational InvMixColumns column unit, one 32-bit column per clock.
//
// Column layout (state_in / state_out): column c occupies bits
// [127-32c : 96-32c], so column 0 is the most significant word.
//
// Parameters
//   COL_ORDER_LSB : 0 = process column [127:96] first, 1 = column [31:0] first.
//
// Optional feature (macro INV_MC_BYPASS_EN)
//   Adds input 'bypass', sampled when a block is accepted. A stored bypass=1
//   makes the block pass through unchanged with identical timing, which is
//   what the final decryption round needs.
//
// Ports
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   in_valid   : input block offered            in_ready  : accepting (IDLE only)
//   state_in   : input state (128)
//   mc_col_o   : column sent to the external unit (0 outside RUN)
//   mc_col_i   : same-cycle result from the external unit
//   out_valid  : state_out holds a finished block (DONE only)
//   out_ready  : consumer accepts state_out
//   state_out  : result register (128)
//   busy       : high in RUN and DONE
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid never depends on ready, and no output depends combinationally on
// in_valid or out_ready.
// -----------------------------------------------------------------------------
module inv_mix_columns_seq #(
   parameter int unsigned COL_ORDER_LSB = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] state_in,
   output logic [31:0]  mc_col_o,
   input  logic [31:0]  mc_col_i,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] state_out,
`ifdef INV_MC_BYPASS_EN
   input  logic         bypass,
`endif
   output logic         busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t       state;
   logic [1:0]   col_idx;
   logic [127:0] in_buf;
   logic [127:0] result;
   logic [1:0]   pos;        // physical column addressed this cycle
   logic [31:0]  buf_col;    // buffered input column at pos
   logic [31:0]  cap_col;    // value written into result column pos
   logic         byp_q;

   // 3 - col_idx is the bitwise inverse for a 2-bit counter.
   assign pos = (COL_ORDER_LSB != 0) ? ~col_idx : col_idx;

   always_comb begin
      buf_col = in_buf[127:96];
      case (pos)
         2'd0:    buf_col = in_buf[127:96];
         2'd1:    buf_col = in_buf[95:64];
         2'd2:    buf_col = in_buf[63:32];
         default: buf_col = in_buf[31:0];
      endcase
   end

   assign cap_col = byp_q ? buf_col : mc_col_i;

   // Outputs are pure decodes of registered state.
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign mc_col_o  = (state == RUN) ? buf_col : 32'h0;
   assign state_out = result;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         col_idx <= 2'd0;
         in_buf  <= '0;
         result  <= '0;
         byp_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  in_buf  <= state_in;
                  col_idx <= 2'd0;
`ifdef INV_MC_BYPASS_EN
                  byp_q   <= bypass;
`else
                  byp_q   <= 1'b0;
`endif
                  state   <= RUN;
               end
            end
            RUN: begin
               case (pos)
                  2'd0:    result[127:96] <= cap_col;
                  2'd1:    result[95:64]  <= cap_col;
                  2'd2:    result[63:32]  <= cap_col;
                  default: result[31:0]   <= cap_col;
               endcase
               col_idx <= col_idx + 2'd1;
               if (col_idx == 2'd3) begin
                  state <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// -----------------------------------------------------------------------------
// tb_inv_mix_columns_seq
//
// Two instances (COL_ORDER_LSB = 0 and 1) share one stimulus stream; each has
// its own behavioural InvMixColumns column unit on mc_col_o -> mc_col_i.
// Expected results come from a GF(2^8) model of InvMixColumns on the whole
// state. With INV_MC_BYPASS_EN defined, a bypass block is also exercised.
// -----------------------------------------------------------------------------
module tb_inv_mix_columns_seq;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic [127:0] state_in;
   logic         out_ready;
   logic         in_ready   [2];
   logic [31:0]  mc_o       [2];
   logic [31:0]  mc_i       [2];
   logic         out_valid  [2];
   logic [127:0] state_out  [2];
   logic         busy       [2];
   logic         byp;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model ----------------
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] b);
      logic [7:0] r = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 4; i++) begin
         if (b[i]) r = r ^ x;
         x = xtime(x);
      end
      return r;
   endfunction

   function automatic logic [31:0] inv_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {gmul(a0,4'd14) ^ gmul(a1,4'd11) ^ gmul(a2,4'd13) ^ gmul(a3,4'd9),
              gmul(a0,4'd9)  ^ gmul(a1,4'd14) ^ gmul(a2,4'd11) ^ gmul(a3,4'd13),
              gmul(a0,4'd13) ^ gmul(a1,4'd9)  ^ gmul(a2,4'd14) ^ gmul(a3,4'd11),
              gmul(a0,4'd11) ^ gmul(a1,4'd13) ^ gmul(a2,4'd9)  ^ gmul(a3,4'd14)};
   endfunction

   function automatic logic [31:0] col_of(input logic [127:0] s, input int c);
      return s[127-32*c -: 32];
   endfunction

   function automatic logic [127:0] model(input logic [127:0] s, input logic b);
      logic [127:0] r;
      if (b) return s;
      for (int c = 0; c < 4; c++) r[127-32*c -: 32] = inv_col(col_of(s, c));
      return r;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // ---------------- DUTs + column units ----------------
   assign mc_i[0] = inv_col(mc_o[0]);
   assign mc_i[1] = inv_col(mc_o[1]);

   inv_mix_columns_seq #(.COL_ORDER_LSB(0)) u_msb (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
      .state_in(state_in), .mc_col_o(mc_o[0]), .mc_col_i(mc_i[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready), .state_out(state_out[0]),
`ifdef INV_MC_BYPASS_EN
      .bypass(byp),
`endif
      .busy(busy[0]));

   inv_mix_columns_seq #(.COL_ORDER_LSB(1)) u_lsb (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
      .state_in(state_in), .mc_col_o(mc_o[1]), .mc_col_i(mc_i[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready), .state_out(state_out[1]),
`ifdef INV_MC_BYPASS_EN
      .bypass(byp),
`endif
      .busy(busy[1]));

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
   endtask

   task automatic check_both_flags(input string tag, input logic rdy, input logic vld, input logic bsy);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("%s_in_ready%0d", tag, i), in_ready[i], rdy);
         check($sformatf("%s_out_valid%0d", tag, i), out_valid[i], vld);
         check($sformatf("%s_busy%0d", tag, i), busy[i], bsy);
      end
   endtask

   // ---------------- drivers ----------------
   // Called at a negedge with both DUTs in IDLE; returns at a negedge in IDLE.
   task automatic run_block(input logic [127:0] d, input int hold);
      logic [127:0] e;
      e = model(d, byp);
      check("pre_in_ready0", in_ready[0], 1'b1);
      check("pre_in_ready1", in_ready[1], 1'b1);
      in_valid = 1'b1;
      state_in = d;
      @(posedge clk);            // acceptance edge
      @(negedge clk);
      in_valid = 1'b0;
      state_in = rnd128();       // must be ignored while busy
      for (int k = 0; k < 4; k++) begin
         check($sformatf("mc_col_msb_k%0d", k), mc_o[0], col_of(d, k));
         check($sformatf("mc_col_lsb_k%0d", k), mc_o[1], col_of(d, 3 - k));
         check_both_flags($sformatf("run%0d", k), 1'b0, 1'b0, 1'b1);
         @(negedge clk);
      end
      // four edges after acceptance
      check_both_flags("done", 1'b0, 1'b1, 1'b1);
      check("result_msb", state_out[0], e);
      check("result_lsb", state_out[1], e);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check_both_flags("hold", 1'b0, 1'b1, 1'b1);
         check("hold_state_msb", state_out[0], e);
         check("hold_state_lsb", state_out[1], e);
         check("hold_mc_zero", {mc_o[0], mc_o[1]}, 64'h0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check_both_flags("after_done", 1'b1, 1'b0, 1'b0);
      check("kept_state_msb", state_out[0], e);
      check("kept_state_lsb", state_out[1], e);
   endtask

   // in_valid held high, out_ready tied high, three blocks through a queue.
   task automatic stream_three();
      logic [127:0] exp_q[$];
      logic [127:0] e;
      int n_acc = 0, n_out = 0, last_acc = 0, t = 0;
      bit   acc_pending = 0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      state_in  = rnd128();
      while ((n_out < 3) && (t < 100)) begin
         if (acc_pending) begin
            acc_pending = 0;
            state_in = rnd128();
            if (n_acc == 3) in_valid = 1'b0;
         end
         if (out_valid[0] || out_valid[1]) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            check("stream_valid_pair", {out_valid[0], out_valid[1]}, 2'b11);
            check("stream_msb", state_out[0], e);
            check("stream_lsb", state_out[1], e);
            n_out++;
         end
         if (in_valid && in_ready[0]) begin
            if (n_acc > 0) check("stream_interval", cyc - last_acc, 6);
            last_acc = cyc;
            exp_q.push_back(model(state_in, byp));
            n_acc++;
            acc_pending = 1;
         end
         @(negedge clk);
         t++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("stream_outputs", n_out, 3);
      check("stream_accepts", n_acc, 3);
      check("stream_queue_empty", exp_q.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   task automatic reset_mid_run(input logic [127:0] d);
      logic saw_valid = 1'b0;
      in_valid = 1'b1;
      state_in = d;
      @(posedge clk);
      @(negedge clk);             // col_idx = 0
      @(negedge clk);             // col_idx = 1
      @(negedge clk);             // col_idx = 2
      check("mid_col2_msb", mc_o[0], col_of(d, 2));
      rst = 1'b1;                 // in_valid still high: reset must win
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;
      check_both_flags("post_rst", 1'b1, 1'b0, 1'b0);
      check("post_rst_state_msb", state_out[0], 128'h0);
      check("post_rst_state_lsb", state_out[1], 128'h0);
      repeat (6) begin
         @(negedge clk);
         saw_valid = saw_valid | out_valid[0] | out_valid[1];
      end
      check("no_aborted_pulse", saw_valid, 1'b0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst = 1'b1; in_valid = 1'b0; state_in = '0; out_ready = 1'b0; byp = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_both_flags("reset", 1'b1, 1'b0, 1'b0);
      check("reset_state_msb", state_out[0], 128'h0);
      check("reset_mc_zero", {mc_o[0], mc_o[1]}, 64'h0);

      // known vector, with a 10-cycle stall in DONE
      check("model_vector", model(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b0),
            128'hdb135345_f20a225c_01010101_c6c6c6c6);
      run_block(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 10);

      for (int i = 0; i < 6; i++) run_block(rnd128(), $urandom_range(0, 3));

      reset_mid_run(rnd128());
      run_block(rnd128(), 1);

      stream_three();

`ifdef INV_MC_BYPASS_EN
      byp = 1'b1;
      run_block(128'h00112233_44556677_8899aabb_ccddeeff, 2);
      run_block(rnd128(), 0);
      byp = 1'b0;
      run_block(rnd128(), 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

endmodule
